// File: rtl/z80_bus_pkg.sv
// ---------------------------------------------------------------------------
// z80_bus_pkg
// Shared definitions for the Z80 bus-cycle sequencer:
//   - machine-cycle command encodings driven by the core on 'cmd'
//   - the T-state enumeration used by the sequencer FSM
//   - small command-classification helpers
// ---------------------------------------------------------------------------
package z80_bus_pkg;

  localparam logic [2:0] CMD_M1   = 3'd0;  // opcode fetch with refresh
  localparam logic [2:0] CMD_MRD  = 3'd1;  // memory read
  localparam logic [2:0] CMD_MWR  = 3'd2;  // memory write
  localparam logic [2:0] CMD_IORD = 3'd3;  // IO read
  localparam logic [2:0] CMD_IOWR = 3'd4;  // IO write

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_T1     = 3'd1,
    S_T2     = 3'd2,
    S_TW     = 3'd3,
    S_T3     = 3'd4,
    S_T4     = 3'd5,
    S_BUSACK = 3'd6
  } tstate_e;

  function automatic logic cmd_valid(input logic [2:0] c);
    return (c <= CMD_IOWR);
  endfunction

  function automatic logic cmd_is_io(input logic [2:0] c);
    return (c == CMD_IORD) || (c == CMD_IOWR);
  endfunction

  function automatic logic cmd_is_wr(input logic [2:0] c);
    return (c == CMD_MWR) || (c == CMD_IOWR);
  endfunction

  // Reads that latch rdata at the end of T3 (M1 latches earlier).
  function automatic logic cmd_is_rd(input logic [2:0] c);
    return (c == CMD_MRD) || (c == CMD_IORD);
  endfunction

endpackage

// File: rtl/z80_refresh_ctr.sv
// ---------------------------------------------------------------------------
// z80_refresh_ctr
// DRAM refresh register R. Bits [6:0] count modulo 128 on each completed
// opcode fetch; bit 7 is never touched by the counter. Also forms the refresh
// address {I, R} driven on A during T3/T4 of an M1 cycle.
// Ports:
//   clk_i        clock (one T-state per edge)
//   rst_i        synchronous active-high reset, loads R_RESET
//   inc_i        advance R[6:0] on this edge
//   i_reg_i      I register (refresh address high byte)
//   rfsh_addr_o  {I, R}
// ---------------------------------------------------------------------------
module z80_refresh_ctr #(
  parameter logic [7:0] R_RESET = 8'h00
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic [7:0]  i_reg_i,
  output logic [15:0] rfsh_addr_o
);

  logic [7:0] r_q;
  logic [7:0] r_d;

  // Next R: low seven bits wrap, bit 7 is carried through unchanged.
  always_comb begin
    r_d = r_q;
    if (inc_i) begin
      r_d = {r_q[7], r_q[6:0] + 7'd1};
    end else begin
      r_d = r_q;
    end
  end

  // R register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_q <= R_RESET;
    end else begin
      r_q <= r_d;
    end
  end

  assign rfsh_addr_o = {i_reg_i, r_q};

endmodule

// File: rtl/z80_bus_seq.sv
// ---------------------------------------------------------------------------
// z80_bus_seq
// T-state accurate Z80 bus-cycle sequencer. Accepts one machine-cycle request
// at a time from the core and produces the pin-level address, data and
// strobe timing, including n_WAIT stretching, M1 refresh and bus handover.
// Every output is a register; each edge computes the values for the T-state
// being entered.
// Ports:
//   CLK, RESET            clock (1 edge = 1 T-state), sync active-high reset
//   req, cmd, addr, wdata core request (cmd: 0 M1, 1 MRD, 2 MWR, 3 IORD, 4 IOWR)
//   i_reg                 I register, refresh high byte
//   done, rdata           completion pulse and read data (held until next done)
//   A, D_in, D_out, D_oe  address bus and split data bus
//   bus_oe                enable for A and the control strobes
//   n_M1..n_RFSH          active-low strobes
//   n_WAIT                active-low wait
//   n_BUSREQ, n_BUSACK    bus request / acknowledge
// Parameters:
//   IO_WAIT     forced TW states after T2 of an IO cycle
//   RESET_ADDR  A value during and after reset
//   R_RESET     reset value of the refresh register R (0 on a real Z80)
// ---------------------------------------------------------------------------
module z80_bus_seq
  import z80_bus_pkg::*;
#(
  parameter int unsigned IO_WAIT    = 1,
  parameter logic [15:0] RESET_ADDR = 16'h0000,
  parameter logic [7:0]  R_RESET    = 8'h00
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req,
  input  logic [2:0]  cmd,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic [7:0]  i_reg,
  output logic        done,
  output logic [7:0]  rdata,
  output logic [15:0] A,
  input  logic [7:0]  D_in,
  output logic [7:0]  D_out,
  output logic        D_oe,
  output logic        bus_oe,
  output logic        n_M1,
  output logic        n_MREQ,
  output logic        n_IORQ,
  output logic        n_RD,
  output logic        n_WR,
  output logic        n_RFSH,
  input  logic        n_WAIT,
  input  logic        n_BUSREQ,
  output logic        n_BUSACK
);

  // The forced-wait counter holds the number of forced TW states still to go
  // after the current one, so it never needs to represent IO_WAIT itself.
  localparam int unsigned   FW_W    = (IO_WAIT > 32'd1) ? $clog2(IO_WAIT) : 1;
  localparam logic [FW_W-1:0] FW_INIT =
    FW_W'((IO_WAIT > 32'd0) ? (IO_WAIT - 32'd1) : 32'd0);
  localparam logic [FW_W-1:0] FW_ONE  = FW_W'(32'd1);
  localparam logic [FW_W-1:0] FW_ZERO = FW_W'(32'd0);

  tstate_e           state_q;
  logic [2:0]        cmd_q;
  logic [FW_W-1:0]   fw_q;
  logic [FW_W-1:0]   fw_d;
  logic [15:0]       a_q;
  logic [7:0]        d_out_q;
  logic [7:0]        rdata_q;
  logic              d_oe_q;
  logic              bus_oe_q;
  logic              done_q;
  logic              n_m1_q;
  logic              n_mreq_q;
  logic              n_iorq_q;
  logic              n_rd_q;
  logic              n_wr_q;
  logic              n_rfsh_q;
  logic              n_busack_q;

  logic              final_s;
  logic              boundary_s;
  logic              accept_s;
  logic              inc_s;
  logic              enter_t3_s;
  logic [15:0]       rfsh_addr_s;

  z80_refresh_ctr #(
    .R_RESET (R_RESET)
  ) u_rfsh (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .inc_i       (inc_s),
    .i_reg_i     (i_reg),
    .rfsh_addr_o (rfsh_addr_s)
  );

  // Cycle boundary decode: M1 ends in T4, every other cycle ends in T3.
  always_comb begin
    final_s    = (state_q == S_T4) || ((state_q == S_T3) && (cmd_q != CMD_M1));
    boundary_s = final_s || (state_q == S_IDLE);
    accept_s   = req && cmd_valid(cmd);
    inc_s      = (state_q == S_T4);
  end

  // Wait handling out of T2/TW: IO cycles first burn the forced TW states,
  // only then does n_WAIT decide between another TW and T3.
  always_comb begin
    enter_t3_s = 1'b0;
    fw_d       = fw_q;
    case (state_q)
      S_T2: begin
        if (cmd_is_io(cmd_q) && (IO_WAIT != 32'd0)) begin
          fw_d = FW_INIT;
        end else if (n_WAIT) begin
          enter_t3_s = 1'b1;
        end else begin
          enter_t3_s = 1'b0;
        end
      end
      S_TW: begin
        if (fw_q != FW_ZERO) begin
          fw_d = fw_q - FW_ONE;
        end else if (n_WAIT) begin
          enter_t3_s = 1'b1;
        end else begin
          enter_t3_s = 1'b0;
        end
      end
      default: begin
        enter_t3_s = 1'b0;
        fw_d       = fw_q;
      end
    endcase
  end

  // Sequencer FSM with all pin outputs registered.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cmd_q      <= CMD_M1;
      fw_q       <= FW_ZERO;
      a_q        <= RESET_ADDR;
      d_out_q    <= 8'h00;
      rdata_q    <= 8'h00;
      d_oe_q     <= 1'b0;
      bus_oe_q   <= 1'b1;
      done_q     <= 1'b0;
      n_m1_q     <= 1'b1;
      n_mreq_q   <= 1'b1;
      n_iorq_q   <= 1'b1;
      n_rd_q     <= 1'b1;
      n_wr_q     <= 1'b1;
      n_rfsh_q   <= 1'b1;
      n_busack_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      fw_q   <= fw_d;
      if (boundary_s) begin
        // Close out the finishing cycle first; a new acceptance below may
        // then override individual strobes for its T1.
        if (final_s) begin
          done_q   <= 1'b1;
          n_m1_q   <= 1'b1;
          n_mreq_q <= 1'b1;
          n_iorq_q <= 1'b1;
          n_rd_q   <= 1'b1;
          n_wr_q   <= 1'b1;
          n_rfsh_q <= 1'b1;
          d_oe_q   <= 1'b0;
          if (cmd_is_rd(cmd_q)) begin
            rdata_q <= D_in;
          end
        end
        // Bus request wins over a pending core request.
        if (!n_BUSREQ) begin
          state_q    <= S_BUSACK;
          n_busack_q <= 1'b0;
          bus_oe_q   <= 1'b0;
          d_oe_q     <= 1'b0;
        end else if (accept_s) begin
          state_q <= S_T1;
          cmd_q   <= cmd;
          a_q     <= addr;
          n_m1_q  <= (cmd != CMD_M1);
          if (cmd_is_wr(cmd)) begin
            d_out_q <= wdata;
            d_oe_q  <= 1'b1;
          end
        end else begin
          state_q <= S_IDLE;
        end
      end else begin
        case (state_q)
          S_T1: begin
            state_q  <= S_T2;
            n_mreq_q <= cmd_is_io(cmd_q);
            n_iorq_q <= !cmd_is_io(cmd_q);
            n_rd_q   <= cmd_is_wr(cmd_q);
            n_wr_q   <= !cmd_is_wr(cmd_q);
          end
          S_T2, S_TW: begin
            if (enter_t3_s) begin
              state_q <= S_T3;
              // M1 latches the opcode here and switches to the refresh phase.
              if (cmd_q == CMD_M1) begin
                rdata_q  <= D_in;
                n_m1_q   <= 1'b1;
                n_rd_q   <= 1'b1;
                n_rfsh_q <= 1'b0;
                a_q      <= rfsh_addr_s;
              end
            end else begin
              state_q <= S_TW;
            end
          end
          // Only an M1 cycle reaches T3 here; others finish at the boundary.
          S_T3: begin
            state_q  <= S_T4;
            n_mreq_q <= 1'b1;
          end
          S_BUSACK: begin
            if (n_BUSREQ) begin
              state_q    <= S_IDLE;
              n_busack_q <= 1'b1;
              bus_oe_q   <= 1'b1;
            end else begin
              state_q <= S_BUSACK;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign done     = done_q;
  assign rdata    = rdata_q;
  assign A        = a_q;
  assign D_out    = d_out_q;
  assign D_oe     = d_oe_q;
  assign bus_oe   = bus_oe_q;
  assign n_M1     = n_m1_q;
  assign n_MREQ   = n_mreq_q;
  assign n_IORQ   = n_iorq_q;
  assign n_RD     = n_rd_q;
  assign n_WR     = n_wr_q;
  assign n_RFSH   = n_rfsh_q;
  assign n_BUSACK = n_busack_q;

endmodule

// File: tb/tb_z80_bus_seq.sv
// ---------------------------------------------------------------------------
// tb_z80_bus_seq
// Directed bench for z80_bus_seq. Two instances share all inputs: 'dut' uses
// a distinctive RESET_ADDR, 'dut_r7' starts with R[7]=1 for the refresh wrap.
// Strobe vectors are ordered {n_M1, n_MREQ, n_IORQ, n_RD, n_WR, n_RFSH}.
// ---------------------------------------------------------------------------
module tb_z80_bus_seq;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req;
  logic [2:0]  cmd;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  i_reg;
  logic [7:0]  D_in;
  logic        n_WAIT;
  logic        n_BUSREQ;

  logic        done, D_oe, bus_oe, n_BUSACK;
  logic [7:0]  rdata, D_out;
  logic [15:0] A;
  logic        n_M1, n_MREQ, n_IORQ, n_RD, n_WR, n_RFSH;

  logic        done2, D_oe2, bus_oe2, n_BUSACK2;
  logic [7:0]  rdata2, D_out2;
  logic [15:0] A2;
  logic        n_M1_2, n_MREQ_2, n_IORQ_2, n_RD_2, n_WR_2, n_RFSH_2;

  logic [5:0]  strb, strb2;
  assign strb  = {n_M1, n_MREQ, n_IORQ, n_RD, n_WR, n_RFSH};
  assign strb2 = {n_M1_2, n_MREQ_2, n_IORQ_2, n_RD_2, n_WR_2, n_RFSH_2};

  localparam logic [5:0] ST_IDLE = 6'b111111;
  localparam logic [5:0] ST_M1T1 = 6'b011111;
  localparam logic [5:0] ST_M1T2 = 6'b001011;
  localparam logic [5:0] ST_M1T3 = 6'b101110;
  localparam logic [5:0] ST_M1T4 = 6'b111110;
  localparam logic [5:0] ST_MRD  = 6'b101011;
  localparam logic [5:0] ST_MWR  = 6'b101101;
  localparam logic [5:0] ST_IOWR = 6'b110101;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  z80_bus_seq #(.IO_WAIT(1), .RESET_ADDR(16'hF00D), .R_RESET(8'h00)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .cmd(cmd), .addr(addr), .wdata(wdata),
    .i_reg(i_reg), .done(done), .rdata(rdata), .A(A), .D_in(D_in), .D_out(D_out),
    .D_oe(D_oe), .bus_oe(bus_oe), .n_M1(n_M1), .n_MREQ(n_MREQ), .n_IORQ(n_IORQ),
    .n_RD(n_RD), .n_WR(n_WR), .n_RFSH(n_RFSH), .n_WAIT(n_WAIT),
    .n_BUSREQ(n_BUSREQ), .n_BUSACK(n_BUSACK)
  );

  z80_bus_seq #(.IO_WAIT(1), .RESET_ADDR(16'h0000), .R_RESET(8'h80)) dut_r7 (
    .CLK(CLK), .RESET(RESET), .req(req), .cmd(cmd), .addr(addr), .wdata(wdata),
    .i_reg(i_reg), .done(done2), .rdata(rdata2), .A(A2), .D_in(D_in), .D_out(D_out2),
    .D_oe(D_oe2), .bus_oe(bus_oe2), .n_M1(n_M1_2), .n_MREQ(n_MREQ_2), .n_IORQ(n_IORQ_2),
    .n_RD(n_RD_2), .n_WR(n_WR_2), .n_RFSH(n_RFSH_2), .n_WAIT(n_WAIT),
    .n_BUSREQ(n_BUSREQ), .n_BUSACK(n_BUSACK2)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET = 1'b1; req = 1'b0; cmd = 3'd0; addr = 16'h0000; wdata = 8'h00;
    i_reg = 8'h80; D_in = 8'h00; n_WAIT = 1'b1; n_BUSREQ = 1'b1;
    step(); step();

    // Reset state
    chk("rst_strb", 32'(strb), 32'(ST_IDLE));
    chk("rst_busack", 32'(n_BUSACK), 32'd1);
    chk("rst_A", 32'(A), 32'hF00D);
    chk("rst_doe", 32'(D_oe), 32'd0);
    chk("rst_busoe", 32'(bus_oe), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst2_strb", 32'(strb2), 32'(ST_IDLE));
    chk("rst2_busack", 32'(n_BUSACK2), 32'd1);
    chk("rst2_A", 32'(A2), 32'h0000);
    chk("rst2_oe", 32'({D_oe2, bus_oe2, done2}), 32'b010);
    chk("rst2_rdata", 32'(rdata2), 32'd0);

    // M1 fetch at 0x1234, opcode 0x3E
    RESET = 1'b0; req = 1'b1; cmd = 3'd0; addr = 16'h1234; D_in = 8'h3E;
    step();                                   // cycle 1: T1
    req = 1'b0;
    chk("m1_t1_A", 32'(A), 32'h1234);
    chk("m1_t1_strb", 32'(strb), 32'(ST_M1T1));
    step();                                   // cycle 2: T2
    chk("m1_t2_A", 32'(A), 32'h1234);
    chk("m1_t2_strb", 32'(strb), 32'(ST_M1T2));
    step();                                   // cycle 3: T3
    D_in = 8'h55;
    chk("m1_t3_A", 32'(A), 32'h8000);
    chk("m1_t3_strb", 32'(strb), 32'(ST_M1T3));
    chk("m1_t3_rdata", 32'(rdata), 32'h3E);
    chk("m1_t3_done", 32'(done), 32'd0);
    step();                                   // cycle 4: T4
    chk("m1_t4_A", 32'(A), 32'h8000);
    chk("m1_t4_strb", 32'(strb), 32'(ST_M1T4));
    chk("m1_t4_done", 32'(done), 32'd0);
    step();                                   // cycle 5: done
    chk("m1_done", 32'(done), 32'd1);
    chk("m1_rdata", 32'(rdata), 32'h3E);
    chk("m1_end_strb", 32'(strb), 32'(ST_IDLE));
    step();
    chk("m1_done_once", 32'(done), 32'd0);

    // Mem read stretched by two wait states
    req = 1'b1; cmd = 3'd1; addr = 16'h4000; D_in = 8'h77;
    step();                                   // cycle 1: T1
    req = 1'b0;
    chk("mrd_t1_A", 32'(A), 32'h4000);
    chk("mrd_t1_strb", 32'(strb), 32'(ST_IDLE));
    step();                                   // cycle 2: T2
    n_WAIT = 1'b0;
    chk("mrd_t2_strb", 32'(strb), 32'(ST_MRD));
    step();                                   // cycle 3: TW
    chk("mrd_tw1_strb", 32'(strb), 32'(ST_MRD));
    step();                                   // cycle 4: TW
    n_WAIT = 1'b1;
    chk("mrd_tw2_done", 32'(done), 32'd0);
    step();                                   // cycle 5: T3
    chk("mrd_t3_strb", 32'(strb), 32'(ST_MRD));
    chk("mrd_t3_done", 32'(done), 32'd0);
    step();                                   // cycle 6: done
    chk("mrd_done", 32'(done), 32'd1);
    chk("mrd_rdata", 32'(rdata), 32'h77);
    chk("mrd_end_strb", 32'(strb), 32'(ST_IDLE));

    // IO write 0xA5 to 0x00FE; n_WAIT low at the T2 edge must be ignored
    req = 1'b1; cmd = 3'd4; addr = 16'h00FE; wdata = 8'hA5;
    step();                                   // cycle 1: T1
    req = 1'b0;
    chk("iow_t1_A", 32'(A), 32'h00FE);
    chk("iow_t1_dout", 32'(D_out), 32'hA5);
    chk("iow_t1_doe", 32'(D_oe), 32'd1);
    step();                                   // cycle 2: T2
    n_WAIT = 1'b0;
    chk("iow_t2_strb", 32'(strb), 32'(ST_IOWR));
    chk("iow_t2_doe", 32'(D_oe), 32'd1);
    step();                                   // cycle 3: forced TW
    n_WAIT = 1'b1;
    chk("iow_tw_strb", 32'(strb), 32'(ST_IOWR));
    step();                                   // cycle 4: T3
    chk("iow_t3_strb", 32'(strb), 32'(ST_IOWR));
    chk("iow_t3_doe", 32'(D_oe), 32'd1);
    chk("iow_t3_done", 32'(done), 32'd0);
    step();                                   // cycle 5: done
    chk("iow_done", 32'(done), 32'd1);
    chk("iow_end_doe", 32'(D_oe), 32'd0);
    chk("iow_end_strb", 32'(strb), 32'(ST_IDLE));

    // Unsupported command is dropped
    req = 1'b1; cmd = 3'd6; addr = 16'h9999;
    step();
    chk("bad_strb", 32'(strb), 32'(ST_IDLE));
    chk("bad_A", 32'(A), 32'h00FE);
    step();
    chk("bad_done", 32'(done), 32'd0);
    chk("bad_A2", 32'(A), 32'h00FE);
    req = 1'b0;

    // Bus request during T3 of a mem write, with a read held pending
    req = 1'b1; cmd = 3'd2; addr = 16'h2222; wdata = 8'h5A;
    step();                                   // T1
    req = 1'b0;
    chk("hw_t1_dout", 32'(D_out), 32'h5A);
    chk("hw_t1_dout2", 32'(D_out2), 32'h5A);
    step();                                   // T2
    chk("hw_t2_strb", 32'(strb), 32'(ST_MWR));
    step();                                   // T3
    chk("hw_t3_strb", 32'(strb), 32'(ST_MWR));
    n_BUSREQ = 1'b0; req = 1'b1; cmd = 3'd1; addr = 16'h3333;
    step();                                   // BUSACK, write done
    chk("hw_done", 32'(done), 32'd1);
    chk("hw_busack", 32'(n_BUSACK), 32'd0);
    chk("hw_busoe", 32'(bus_oe), 32'd0);
    chk("hw_doe", 32'(D_oe), 32'd0);
    step();                                   // still BUSACK
    n_BUSREQ = 1'b1;
    chk("hw_hold_busack", 32'(n_BUSACK), 32'd0);
    chk("hw_hold_done", 32'(done), 32'd0);
    step();                                   // IDLE, req not yet accepted
    chk("hw_rel_busack", 32'(n_BUSACK), 32'd1);
    chk("hw_rel_busoe", 32'(bus_oe), 32'd1);
    chk("hw_rel_A", 32'(A), 32'h2222);
    step();                                   // T1 of held read
    req = 1'b0;
    chk("hw_acc_A", 32'(A), 32'h3333);
    step();                                   // T2
    chk("hw_rd_t2_strb", 32'(strb), 32'(ST_MRD));

    // Reset in T2 of the mem read
    RESET = 1'b1;
    step();
    chk("rmid_strb", 32'(strb), 32'(ST_IDLE));
    chk("rmid_A", 32'(A), 32'hF00D);
    chk("rmid_done", 32'(done), 32'd0);
    step();
    chk("rmid_done2", 32'(done), 32'd0);

    // Back-to-back fetches: R counts 0..127 and wraps, R[7] held
    RESET = 1'b0; req = 1'b1; cmd = 3'd0; addr = 16'h0100; D_in = 8'h00;
    for (int k = 0; k <= 128; k++) begin
      logic [7:0] kb;
      kb = 8'(k);
      step();                                 // T1
      chk($sformatf("wrap_done_k%0d", k), 32'(done), (k > 0) ? 32'd1 : 32'd0);
      step();                                 // T2
      step();                                 // T3
      chk($sformatf("wrap_A_k%0d", k), 32'(A), 32'({8'h80, 1'b0, kb[6:0]}));
      chk($sformatf("wrap_A2_k%0d", k), 32'(A2), 32'({8'h80, 1'b1, kb[6:0]}));
      step();                                 // T4
    end
    req = 1'b0;
    step();
    chk("wrap_last_done", 32'(done), 32'd1);
    step();
    chk("wrap_idle_strb", 32'(strb), 32'(ST_IDLE));
    chk("wrap_idle_done", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
